// File: rtl/sync_fifo_param_if.sv
// Handshake/status bundle between a producer/consumer and sync_fifo_param.
// The FIFO connects through the slave modport; its user connects through master.
interface sync_fifo_param_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) ();
    logic              wrreq;
    logic [DATA_W-1:0] data;
    logic              rdreq;
    logic [DATA_W-1:0] q;
    logic              empty;
    logic              full;
    logic              almost_empty;
    logic              almost_full;
    logic [ADDR_W:0]   usedw;
    logic              overflow;
    logic              underflow;

    modport master (
        output wrreq, data, rdreq,
        input  q, empty, full, almost_empty, almost_full, usedw, overflow, underflow
    );

    modport slave (
        input  wrreq, data, rdreq,
        output q, empty, full, almost_empty, almost_full, usedw, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Parameterised single-clock FIFO with programmable thresholds and sticky error flags.
// Define FIFO_SHOWAHEAD_EN for show-ahead mode (head word visible while not empty).
module sync_fifo_param #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 8,
    parameter int AE_THRESH = 2,
    parameter int AF_THRESH = 254
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclr,
    sync_fifo_param_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LP_AE    = (ADDR_W+1)'(AE_THRESH);
    localparam logic [ADDR_W:0] LP_AF    = (ADDR_W+1)'(AF_THRESH);

    if (AE_THRESH < 0 || AE_THRESH > DEPTH) begin : g_badAeThresh
        $error("sync_fifo_param: AE_THRESH=%0d outside 0..%0d", AE_THRESH, DEPTH);
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_badAfThresh
        $error("sync_fifo_param: AF_THRESH=%0d outside 1..%0d", AF_THRESH, DEPTH);
    end

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wrPtr;
    logic [ADDR_W-1:0] r_rdPtr;
    logic [ADDR_W:0]   r_usedw;
    logic              r_empty;
    logic              r_full;
    logic              r_almostEmpty;
    logic              r_almostFull;
    logic              r_overflow;
    logic              r_underflow;
    logic [DATA_W-1:0] r_q;

    logic              w_clear;
    logic              w_wrAcc;
    logic              w_rdAcc;
    logic [ADDR_W:0]   w_usedwNext;

    assign w_clear     = rst | sclr;
    assign w_wrAcc     = bus.wrreq & ~r_full;
    assign w_rdAcc     = bus.rdreq & ~r_empty;
    assign w_usedwNext = r_usedw + (ADDR_W+1)'(w_wrAcc) - (ADDR_W+1)'(w_rdAcc);

    // Storage has no reset so it can map onto block RAM; a clear still blocks the write.
    always_ff @(posedge clk) begin
        if (w_wrAcc && !w_clear) begin
            r_mem[r_wrPtr] <= bus.data;
        end
    end

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_wrPtr       <= '0;
            r_rdPtr       <= '0;
            r_usedw       <= '0;
            r_empty       <= 1'b1;
            r_full        <= 1'b0;
            r_almostEmpty <= (LP_AE != '0);
            r_almostFull  <= 1'b0;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
            r_q           <= '0;
        end else begin
            if (w_wrAcc) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_rdAcc) begin
                r_rdPtr <= r_rdPtr + 1'b1;
                r_q     <= r_mem[r_rdPtr];
            end
            // Flags come from the next count so they move on the same edge as usedw.
            r_usedw       <= w_usedwNext;
            r_empty       <= (w_usedwNext == '0);
            r_full        <= (w_usedwNext == LP_DEPTH);
            r_almostEmpty <= (w_usedwNext < LP_AE);
            r_almostFull  <= (w_usedwNext >= LP_AF);
            r_overflow    <= r_overflow  | (bus.wrreq & r_full);
            r_underflow   <= r_underflow | (bus.rdreq & r_empty);
        end
    end

`ifdef FIFO_SHOWAHEAD_EN
    // r_q holds the last popped word, which is what q shows once the FIFO runs dry.
    assign bus.q = r_empty ? r_q : r_mem[r_rdPtr];
`else
    assign bus.q = r_q;
`endif

    assign bus.empty        = r_empty;
    assign bus.full         = r_full;
    assign bus.almost_empty = r_almostEmpty;
    assign bus.almost_full  = r_almostFull;
    assign bus.usedw        = r_usedw;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: a vector table for short sequences, then
// longer fill/drain/wrap/clear sequences checked against a queue reference.
module tb_sync_fifo_param;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;
    localparam int AE     = 2;
    localparam int AF     = 254;
`ifdef FIFO_SHOWAHEAD_EN
    localparam bit SHOWAHEAD = 1'b1;
`else
    localparam bit SHOWAHEAD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic sclr;

    sync_fifo_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    sync_fifo_param #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .AE_THRESH(AE),
        .AF_THRESH(AF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sclr(sclr),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, sclr, wr, rd;
        logic [15:0] din;
        logic [8:0]  usedw;
        logic        empty, full, ae, af, ovf, unf;
        logic [15:0] qNorm, qShow;
    } vec_t;

    int          nVec = 0;
    int          nBad = 0;
    logic [15:0] mdl[$];
    logic        mOvf = 1'b0;
    logic        mUnf = 1'b0;
    logic [15:0] mQ   = '0;
    vec_t        vecs[14];

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            nBad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic [8:0] usedw, input logic empty,
                               input logic full, input logic ae, input logic af,
                               input logic ovf, input logic unf, input logic [15:0] q);
        nVec++;
        checkField({name, ".usedw"},        32'(bus.usedw),        32'(usedw));
        checkField({name, ".empty"},        32'(bus.empty),        32'(empty));
        checkField({name, ".full"},         32'(bus.full),         32'(full));
        checkField({name, ".almost_empty"}, 32'(bus.almost_empty), 32'(ae));
        checkField({name, ".almost_full"},  32'(bus.almost_full),  32'(af));
        checkField({name, ".overflow"},     32'(bus.overflow),     32'(ovf));
        checkField({name, ".underflow"},    32'(bus.underflow),    32'(unf));
        checkField({name, ".q"},            32'(bus.q),            32'(q));
    endtask

    // Expected outputs derived from the reference queue rather than hand tables.
    task automatic checkModel(input string name);
        int          n;
        logic [15:0] expQ;
        n = mdl.size();
        if (SHOWAHEAD && n > 0) expQ = mdl[0];
        else                    expQ = mQ;
        checkOutput(name, 9'(n), n == 0, n == DEPTH, n < AE, n >= AF, mOvf, mUnf, expQ);
    endtask

    task automatic applyStimulus(input logic iRst, input logic iSclr, input logic iWr,
                                 input logic iRd, input logic [15:0] iData);
        bit wrAcc;
        bit rdAcc;
        rst       = iRst;
        sclr      = iSclr;
        bus.wrreq = iWr;
        bus.rdreq = iRd;
        bus.data  = iData;
        @(posedge clk);
        #1;
        if (iRst || iSclr) begin
            mdl.delete();
            mOvf = 1'b0;
            mUnf = 1'b0;
            mQ   = '0;
        end else begin
            wrAcc = iWr && (mdl.size() < DEPTH);
            rdAcc = iRd && (mdl.size() > 0);
            if (iWr && !wrAcc) mOvf = 1'b1;
            if (iRd && !rdAcc) mUnf = 1'b1;
            if (rdAcc) mQ = mdl.pop_front();
            if (wrAcc) mdl.push_back(iData);
        end
    endtask

    initial begin
        rst       = 1'b1;
        sclr      = 1'b0;
        bus.wrreq = 1'b0;
        bus.rdreq = 1'b0;
        bus.data  = '0;

        //           rst  sclr wr   rd   din       usedw emp full ae af ovf unf qNorm     qShow
        vecs[0]  = '{1'b1,1'b0,1'b1,1'b1,16'hAAAA, 9'd0, 1,  0,   1, 0, 0,  0,  16'h0000, 16'h0000};
        vecs[1]  = '{1'b1,1'b0,1'b1,1'b1,16'hAAAA, 9'd0, 1,  0,   1, 0, 0,  0,  16'h0000, 16'h0000};
        vecs[2]  = '{1'b0,1'b0,1'b0,1'b1,16'h0000, 9'd0, 1,  0,   1, 0, 0,  1,  16'h0000, 16'h0000};
        vecs[3]  = '{1'b0,1'b0,1'b1,1'b0,16'h1111, 9'd1, 0,  0,   1, 0, 0,  1,  16'h0000, 16'h1111};
        vecs[4]  = '{1'b0,1'b0,1'b1,1'b0,16'h2222, 9'd2, 0,  0,   0, 0, 0,  1,  16'h0000, 16'h1111};
        vecs[5]  = '{1'b0,1'b0,1'b1,1'b1,16'h3333, 9'd2, 0,  0,   0, 0, 0,  1,  16'h1111, 16'h2222};
        vecs[6]  = '{1'b0,1'b0,1'b0,1'b1,16'h0000, 9'd1, 0,  0,   1, 0, 0,  1,  16'h2222, 16'h3333};
        vecs[7]  = '{1'b0,1'b0,1'b0,1'b1,16'h0000, 9'd0, 1,  0,   1, 0, 0,  1,  16'h3333, 16'h3333};
        vecs[8]  = '{1'b0,1'b0,1'b1,1'b1,16'h4444, 9'd1, 0,  0,   1, 0, 0,  1,  16'h3333, 16'h4444};
        vecs[9]  = '{1'b0,1'b1,1'b1,1'b0,16'h5555, 9'd0, 1,  0,   1, 0, 0,  0,  16'h0000, 16'h0000};
        vecs[10] = '{1'b0,1'b0,1'b0,1'b1,16'h0000, 9'd0, 1,  0,   1, 0, 0,  1,  16'h0000, 16'h0000};
        vecs[11] = '{1'b0,1'b1,1'b0,1'b0,16'h0000, 9'd0, 1,  0,   1, 0, 0,  0,  16'h0000, 16'h0000};
        vecs[12] = '{1'b0,1'b0,1'b1,1'b0,16'h6666, 9'd1, 0,  0,   1, 0, 0,  0,  16'h0000, 16'h6666};
        vecs[13] = '{1'b0,1'b0,1'b0,1'b1,16'h0000, 9'd0, 1,  0,   1, 0, 0,  0,  16'h6666, 16'h6666};

        for (int k = 0; k < 14; k++) begin
            applyStimulus(vecs[k].rst, vecs[k].sclr, vecs[k].wr, vecs[k].rd, vecs[k].din);
            checkOutput($sformatf("vec%0d", k), vecs[k].usedw, vecs[k].empty, vecs[k].full,
                        vecs[k].ae, vecs[k].af, vecs[k].ovf, vecs[k].unf,
                        SHOWAHEAD ? vecs[k].qShow : vecs[k].qNorm);
        end

        // Fill to full, then one write too many.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'(i));
            checkModel($sformatf("fill%0d", i));
        end
        checkOutput("full256", 9'd256, 0, 1, 0, 1, 0, 0, 16'h0000);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'hDEAD);
        checkOutput("overflow", 9'd256, 0, 1, 0, 1, 1, 0, 16'h0000);

        // Drain completely, then one read too many.
        for (int i = 0; i <= DEPTH; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
            checkModel($sformatf("drain%0d", i));
        end
        checkOutput("underflow", 9'd0, 1, 0, 1, 0, 1, 1, 16'd255);

        // Steady-state pass-through at usedw=100, then both requests while full.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 100; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'(1000 + i));
        for (int i = 0; i < 50; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 16'(2000 + i));
            checkModel($sformatf("pass%0d", i));
        end
        for (int i = 0; i < 156; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'(3000 + i));
        checkModel("refull");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 16'hBEEF);
        checkOutput("fullBoth", 9'd255, 0, 0, 0, 1, 1, 0, SHOWAHEAD ? 16'd1051 : 16'd1050);
        for (int i = 0; i < 255; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
            checkModel($sformatf("order%0d", i));
        end

        // Pointer wrap: 200 through, then 100 more crossing the rollover.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 200; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'(i * 3));
        for (int i = 0; i < 200; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
            checkModel($sformatf("wrapA%0d", i));
        end
        for (int i = 0; i < 100; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'(16'h8000 + i));
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
            checkModel($sformatf("wrapB%0d", i));
        end

        // Clear at usedw=37 with overflow set and a concurrent write.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'(i));
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'hDEAD);
        for (int i = 0; i < 219; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
        checkOutput("at37", 9'd37, 0, 0, 0, 0, 1, 0, SHOWAHEAD ? 16'd219 : 16'd218);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h7777);
        checkOutput("sclr", 9'd0, 1, 0, 1, 0, 0, 0, 16'h0000);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h1234);
        checkOutput("postClrWr", 9'd1, 0, 0, 1, 0, 0, 0, SHOWAHEAD ? 16'h1234 : 16'h0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
        checkOutput("postClrRd", 9'd0, 1, 0, 1, 0, 0, 0, 16'h1234);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end
endmodule
